rr_vc_arbiter: RTL and testbench
================================

RR_VC_ARBITER -- requirements
Module: rr_vc_arbiter

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: virtual channels per virtual network, legal values 1..16.
REQ-002 SHALL have parameter NUM_VN, default 3: independent virtual networks, legal values 1..8.
REQ-003 SHALL have parameter LOCK_MODE, default 1: 1 holds a grant until release, 0 re-arbitrates every cycle.
REQ-004 SHALL define IW = max(1, clog2(NUM_VC)) as the grant index width.
REQ-005 SHALL have port clk, input, 1: the only clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port req_in, input, NUM_VN*NUM_VC: requests; VN v occupies bits [v*NUM_VC +: NUM_VC].
REQ-008 SHALL have port release_in, input, NUM_VN: per-VN end-of-packet release of the held grant; ignored when LOCK_MODE=0.
REQ-009 SHALL have port grant_out, input-aligned, output, NUM_VN*NUM_VC: registered grants, one-hot or zero per VN.
REQ-010 SHALL have port grant_vld_out, output, NUM_VN: per-VN OR of that VN's grant_out slice.
REQ-011 SHALL have port grant_idx_out, output, NUM_VN*IW: per-VN binary index of the granted VC; 0 when no grant.

Function
REQ-012 SHALL contain NUM_VN identical arbiters with no shared state; activity in one VN never affects another.
REQ-013 SHALL hold, per VN, a priority pointer ptr (IW bits, range 0..NUM_VC-1) and a state of IDLE or LOCKED.
REQ-014 SHALL select, in IDLE, the first requesting VC at or after ptr, searching upward and wrapping from NUM_VC-1 to 0.
REQ-015 SHALL register the selection, so a grant appears on grant_out exactly 1 cycle after the request is sampled.
REQ-016 SHALL, on a grant to VC k, load ptr with (k+1) mod NUM_VC in the same edge that registers the grant.
REQ-017 SHALL leave ptr and the grant registers unchanged when no VC in that VN requests in IDLE; the grant reads zero.
REQ-018 SHALL, with LOCK_MODE=1, move IDLE->LOCKED on the edge that registers a grant.
REQ-019 SHALL, with LOCK_MODE=1 in LOCKED, hold grant_out constant while the granted request stays high and release_in[v]=0.
REQ-020 SHALL, in LOCKED with release_in[v]=1, re-arbitrate that cycle using the updated ptr and register the result at the next edge.
REQ-021 SHALL, for REQ-020, make the released VC eligible only if no other VC requests, so there is no bubble and no starvation.
REQ-022 SHALL, in LOCKED when the granted VC drops its request without release, treat it as a release (REQ-020).
REQ-023 SHALL, with LOCK_MODE=0, never enter LOCKED and apply REQ-014..REQ-017 every cycle.
REQ-024 SHALL ignore release_in[v] in IDLE.
REQ-025 SHALL, with NUM_VC=1, grant VC0 whenever it requests; ptr stays 0.
REQ-026 SHALL guarantee that every continuously asserted request is granted within NUM_VC grant epochs of its VN.
REQ-027 SHALL never assert more than one grant bit per VN in any cycle.
REQ-028 SHALL drive grant_vld_out and grant_idx_out combinationally from the grant registers only.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, clear all grant_out bits, set every ptr to 0 and every state to IDLE.
REQ-030 SHALL, with rst_n=0, hold grant_vld_out=0 and grant_idx_out=0 for all VNs, regardless of req_in and release_in.
REQ-031 SHALL, when reset is asserted mid-packet while LOCKED, drop the grant at that edge with no release required.
REQ-032 SHALL give the first grant no earlier than 1 cycle after the first edge with rst_n=1.

Verification
REQ-033 SHALL cover: after reset, NUM_VC=4, VN0 req=4'b1111, LOCK_MODE=0 -> grants VC0,1,2,3,0 on consecutive cycles, the first at reset+1.
REQ-034 SHALL cover: LOCK_MODE=1, VN0 req=4'b0110 -> VC1 is held; pulse release_in[0] -> VC2 next cycle with no idle cycle.
REQ-035 SHALL cover: LOCK_MODE=1, VC2 is held and drops its request without release, others idle -> grant=0 next cycle and ptr=3.
REQ-036 SHALL cover: VN0 and VN1 with different request patterns and releases on the same cycles -> grant sequences match independent golden models.
REQ-037 SHALL cover: rst_n pulled low while VN1 is LOCKED on VC3 -> all grants are 0 at that edge; after release of reset, req=4'b1000 -> VC3 granted with ptr restarted from 0.
REQ-038 SHALL cover: NUM_VC=1, req toggles each cycle -> the grant follows the request with 1-cycle latency and grant_idx_out stays 0.

Source files
------------

// File: rtl/rr_vc_arbiter_if.sv
// rr_vc_arbiter_if: request/release/grant bundle for the per-VN round-robin arbiter
interface rr_vc_arbiter_if #(
  parameter int NUM_VC = 4,
  parameter int NUM_VN = 3,
  parameter int IW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
  logic [NUM_VN*NUM_VC-1:0] req_in;
  logic [NUM_VN-1:0]        release_in;
  logic [NUM_VN*NUM_VC-1:0] grant_out;
  logic [NUM_VN-1:0]        grant_vld_out;
  logic [NUM_VN*IW-1:0]     grant_idx_out;
  modport master (output req_in, release_in, input grant_out, grant_vld_out, grant_idx_out);
  modport slave  (input req_in, release_in, output grant_out, grant_vld_out, grant_idx_out);
endinterface

// File: rtl/rr_vc_arbiter.sv
// rr_vc_arbiter: independent round-robin VC arbiters, one per virtual network, with optional grant locking
module rr_vc_arbiter #(
  parameter int NUM_VC    = 4,
  parameter int NUM_VN    = 3,
  parameter int LOCK_MODE = 1
) (
  input logic             clk,
  input logic             rst_n,
  rr_vc_arbiter_if.slave  bus
);
  localparam int IW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  genvar v;
  for (v = 0; v < NUM_VN; v++) begin : g_vn
    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_ptr, w_ptr_nxt, w_sel, w_k, w_idx;
    logic [NUM_VC-1:0] r_gnt, w_gnt_nxt, w_req;
    logic              w_any, w_arb;
    assign w_req = bus.req_in[v*NUM_VC +: NUM_VC];
    // first requesting VC at or after ptr; the just-granted VC sits last because ptr already moved past it
    always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      w_k   = '0;
      for (int i = 0; i < NUM_VC; i++) begin
        w_k = IW'((int'(r_ptr) + i) % NUM_VC);
        if (!w_any && w_req[w_k]) begin
          w_sel = w_k;
          w_any = 1'b1;
        end
      end
    end
    // next state: arbitrate when idle, unlocked, released, or the held request has dropped
    always_comb begin
      w_arb       = (LOCK_MODE == 0) || (r_state == IDLE) || bus.release_in[v] || !(|(w_req & r_gnt));
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      if (w_arb) begin
        w_gnt_nxt   = w_any ? (NUM_VC'(1) << w_sel) : '0;
        w_ptr_nxt   = !w_any ? r_ptr : (w_sel == IW'(NUM_VC - 1)) ? '0 : w_sel + 1'b1;
        w_state_nxt = (w_any && LOCK_MODE != 0) ? LOCKED : IDLE;
      end
    end
    // state, pointer and grant registers
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_ptr   <= '0;
        r_gnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_ptr   <= w_ptr_nxt;
        r_gnt   <= w_gnt_nxt;
      end
    end
    // binary index of the one-hot grant register
    always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_VC; i++)
        if (r_gnt[i]) w_idx = IW'(i);
    end
    assign bus.grant_out[v*NUM_VC +: NUM_VC] = r_gnt;
    assign bus.grant_vld_out[v]              = |r_gnt;
    assign bus.grant_idx_out[v*IW +: IW]     = w_idx;
  end
endmodule

// File: tb/tb_rr_vc_arbiter.sv
// tb_rr_vc_arbiter: directed vectors with a queued scoreboard over three arbiter configurations
module tb_rr_vc_arbiter;
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  rr_vc_arbiter_if #(.NUM_VC(4), .NUM_VN(1)) ia();
  rr_vc_arbiter_if #(.NUM_VC(4), .NUM_VN(2)) ib();
  rr_vc_arbiter_if #(.NUM_VC(1), .NUM_VN(1)) ic();
  rr_vc_arbiter #(.NUM_VC(4), .NUM_VN(1), .LOCK_MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  rr_vc_arbiter #(.NUM_VC(4), .NUM_VN(2), .LOCK_MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  rr_vc_arbiter #(.NUM_VC(1), .NUM_VN(1), .LOCK_MODE(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));
  typedef struct packed {logic [3:0] a; logic [7:0] b; logic c;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] enc(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant_a", 8'(ia.grant_out), 8'(e.a));
      chk("vld_a", 8'(ia.grant_vld_out), 8'(|e.a));
      chk("idx_a", 8'(ia.grant_idx_out), 8'(enc(e.a)));
      chk("grant_b", ib.grant_out, e.b);
      chk("vld_b", 8'(ib.grant_vld_out), 8'({|e.b[7:4], |e.b[3:0]}));
      chk("idx_b", 8'(ib.grant_idx_out), 8'({enc(e.b[7:4]), enc(e.b[3:0])}));
      chk("grant_c", 8'(ic.grant_out), 8'(e.c));
      chk("vld_c", 8'(ic.grant_vld_out), 8'(e.c));
      chk("idx_c", 8'(ic.grant_idx_out), 8'd0);
    end
  end
  task automatic row(input logic rn, input logic [3:0] ra, input logic [7:0] rb, input logic [1:0] lb,
                     input logic rc, input logic [3:0] ea, input logic [7:0] eb, input logic ec);
    @(negedge clk);
    rst_n         = rn;
    ia.req_in     = ra;
    ia.release_in = 1'b0;
    ib.req_in     = rb;
    ib.release_in = lb;
    ic.req_in     = rc;
    ic.release_in = 1'b0;
    q.push_back('{ea, eb, ec});
  endtask
  initial begin
    rst_n = 1'b0;
    ia.req_in = '0; ia.release_in = '0;
    ib.req_in = '0; ib.release_in = '0;
    ic.req_in = '0; ic.release_in = '0;
    row(0, 4'hF, 8'hFF, 2'b11, 1, 4'h0, 8'h00, 0);
    row(0, 4'hF, 8'hFF, 2'b11, 1, 4'h0, 8'h00, 0);
    row(1, 4'hF, 8'h00, 2'b00, 1, 4'h1, 8'h00, 1);
    row(1, 4'hF, 8'h00, 2'b00, 0, 4'h2, 8'h00, 0);
    row(1, 4'hF, 8'h00, 2'b00, 1, 4'h4, 8'h00, 1);
    row(1, 4'hF, 8'h00, 2'b00, 0, 4'h8, 8'h00, 0);
    row(1, 4'hF, 8'h00, 2'b00, 1, 4'h1, 8'h00, 1);
    row(1, 4'h0, 8'h00, 2'b11, 0, 4'h0, 8'h00, 0);
    row(1, 4'h0, 8'h06, 2'b00, 0, 4'h0, 8'h02, 0);
    row(1, 4'h0, 8'h06, 2'b00, 0, 4'h0, 8'h02, 0);
    row(1, 4'h0, 8'h06, 2'b00, 0, 4'h0, 8'h02, 0);
    row(1, 4'h0, 8'h06, 2'b01, 0, 4'h0, 8'h04, 0);
    row(1, 4'h0, 8'h06, 2'b00, 0, 4'h0, 8'h04, 0);
    row(1, 4'h0, 8'h00, 2'b00, 0, 4'h0, 8'h00, 0);
    row(1, 4'h0, 8'h0F, 2'b00, 0, 4'h0, 8'h08, 0);
    row(1, 4'h0, 8'h0F, 2'b01, 0, 4'h0, 8'h01, 0);
    row(1, 4'h0, 8'h00, 2'b00, 0, 4'h0, 8'h00, 0);
    row(1, 4'h0, 8'h7A, 2'b00, 0, 4'h0, 8'h12, 0);
    row(1, 4'h0, 8'h7A, 2'b11, 0, 4'h0, 8'h28, 0);
    row(1, 4'h0, 8'h7A, 2'b11, 0, 4'h0, 8'h42, 0);
    row(1, 4'h0, 8'h7A, 2'b00, 0, 4'h0, 8'h42, 0);
    row(1, 4'h0, 8'h4A, 2'b11, 0, 4'h0, 8'h48, 0);
    row(1, 4'h0, 8'h40, 2'b00, 0, 4'h0, 8'h40, 0);
    row(1, 4'h0, 8'h80, 2'b00, 0, 4'h0, 8'h80, 0);
    row(1, 4'h0, 8'h80, 2'b00, 0, 4'h0, 8'h80, 0);
    row(0, 4'h0, 8'h80, 2'b00, 0, 4'h0, 8'h00, 0);
    row(1, 4'h0, 8'h80, 2'b00, 0, 4'h0, 8'h80, 0);
    row(1, 4'h0, 8'h80, 2'b10, 0, 4'h0, 8'h80, 0);
    row(1, 4'h0, 8'h00, 2'b00, 0, 4'h0, 8'h00, 0);
    @(negedge clk);
    chk("drain", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
